grf_wb: RTL and testbench

General register file and write-back stage of the single-cycle MIPS datapath, sitting directly downstream of the data memory. It consumes the write-back word (`RegData`, already selected by `MemtoReg`) together with the destination register and `RegWr`. It commits that word into one of 32 general registers on the clock edge and serves two combinational read ports to the ALU/DM path. It also keeps a registered write-back trace (PC, register, data, count) that the verification bench and the on-board debug display consume.

---
 rtl/mips_pkg.sv | 9 +
 rtl/grf_rport.sv | 16 +
 rtl/grf_wb.sv | 56 +++++
 tb/tb_grf_wb.sv | 189 ++++++++++++++++++
 4 files changed

// File: rtl/mips_pkg.sv
// mips_pkg: shared widths and types for the MIPS datapath blocks
package mips_pkg;
    localparam int REG_NUM = 32;
    localparam int REG_AW = 5;
    localparam int WORD_W = 32;
    typedef logic [WORD_W-1:0] word_t;
    typedef logic [REG_AW-1:0] regidx_t;
    localparam regidx_t ZERO_REG = 5'd0;
endpackage

// File: rtl/grf_rport.sv
// grf_rport: one combinational register-file read port with $0 and write-through handling
module grf_rport
    import mips_pkg::*;
#(
    parameter int BYPASS = 1
) (
    input  regidx_t addr,
    input  regidx_t wr_addr,
    input  word_t   wd,
    input  logic    we,
    input  word_t   regs [1:REG_NUM-1],
    output word_t   rd
);
    assign rd = (addr == ZERO_REG) ? '0 :
                ((BYPASS != 0) && we && addr == wr_addr) ? wd : regs[addr];
endmodule

// File: rtl/grf_wb.sv
// grf_wb: 31-entry general register file with write-back trace capture
module grf_wb
    import mips_pkg::*;
#(
    parameter int BYPASS = 1,
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  regidx_t          A1,
    input  regidx_t          A2,
    input  regidx_t          A3,
    input  word_t            WD,
    input  logic             RegWr,
    input  word_t            PC,
    output word_t            RD1,
    output word_t            RD2,
    output logic             wb_valid,
    output word_t            wb_pc,
    output regidx_t          wb_reg,
    output word_t            wb_data,
    output logic [CNT_W-1:0] wb_count
);
    word_t regs [1:REG_NUM-1];
    grf_rport #(.BYPASS(BYPASS)) u_rp1 (
        .addr(A1), .wr_addr(A3), .wd(WD), .we(RegWr), .regs(regs), .rd(RD1)
    );
    grf_rport #(.BYPASS(BYPASS)) u_rp2 (
        .addr(A2), .wr_addr(A3), .wd(WD), .we(RegWr), .regs(regs), .rd(RD2)
    );
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 1; i < REG_NUM; i++) regs[i] <= '0;
        end else if (RegWr && A3 != ZERO_REG) begin
            regs[A3] <= WD;
        end
    end
    // writes to $0 are still traced, with the committed value reported as 0
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wb_valid <= 1'b0;
            wb_pc    <= '0;
            wb_reg   <= '0;
            wb_data  <= '0;
            wb_count <= '0;
        end else begin
            wb_valid <= RegWr;
            if (RegWr) begin
                wb_pc    <= PC;
                wb_reg   <= A3;
                wb_data  <= (A3 == ZERO_REG) ? '0 : WD;
                wb_count <= wb_count + CNT_W'(1);
            end
        end
    end
endmodule

// File: tb/tb_grf_wb.sv
// tb_grf_wb: directed plus random checks of grf_wb against an array-based reference model
module tb_grf_wb;
    import mips_pkg::*;
    logic clk = 1'b0;
    logic reset;
    regidx_t A1, A2, A3;
    word_t WD, PC;
    logic RegWr;
    word_t rd1, rd2, rd1_nb, rd2_nb, rd1_c3, rd2_c3;
    logic valid, valid_nb, valid_c3;
    word_t pc_o, pc_nb, pc_c3, data_o, data_nb, data_c3;
    regidx_t reg_o, reg_nb, reg_c3;
    logic [31:0] cnt, cnt_nb;
    logic [2:0] cnt_c3;
    int n_cmp = 0;
    int n_err = 0;
    word_t m_regs [32];
    logic m_valid;
    word_t m_pc, m_data;
    regidx_t m_reg;
    int unsigned m_count;

    grf_wb u_dut (
        .clk(clk), .reset(reset), .A1(A1), .A2(A2), .A3(A3), .WD(WD), .RegWr(RegWr), .PC(PC),
        .RD1(rd1), .RD2(rd2), .wb_valid(valid), .wb_pc(pc_o), .wb_reg(reg_o),
        .wb_data(data_o), .wb_count(cnt)
    );
    grf_wb #(.BYPASS(0)) u_nb (
        .clk(clk), .reset(reset), .A1(A1), .A2(A2), .A3(A3), .WD(WD), .RegWr(RegWr), .PC(PC),
        .RD1(rd1_nb), .RD2(rd2_nb), .wb_valid(valid_nb), .wb_pc(pc_nb), .wb_reg(reg_nb),
        .wb_data(data_nb), .wb_count(cnt_nb)
    );
    grf_wb #(.CNT_W(3)) u_c3 (
        .clk(clk), .reset(reset), .A1(A1), .A2(A2), .A3(A3), .WD(WD), .RegWr(RegWr), .PC(PC),
        .RD1(rd1_c3), .RD2(rd2_c3), .wb_valid(valid_c3), .wb_pc(pc_c3), .wb_reg(reg_c3),
        .wb_data(data_c3), .wb_count(cnt_c3)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic model_clear();
        for (int i = 0; i < 32; i++) m_regs[i] = '0;
        m_valid = 1'b0;
        m_pc = '0;
        m_reg = '0;
        m_data = '0;
        m_count = 0;
    endtask

    function automatic word_t exp_rd(input regidx_t a, input bit byp);
        if (a == 5'd0) return '0;
        if (byp && RegWr && a == A3) return WD;
        return m_regs[a];
    endfunction

    task automatic drive(input regidx_t a1, input regidx_t a2, input regidx_t a3,
                         input word_t wd, input logic we, input word_t pc);
        A1 = a1; A2 = a2; A3 = a3; WD = wd; RegWr = we; PC = pc;
    endtask

    task automatic tick();
        @(posedge clk);
        if (reset) model_clear();
        else if (RegWr) begin
            if (A3 != 5'd0) m_regs[A3] = WD;
            m_valid = 1'b1;
            m_pc = PC;
            m_reg = A3;
            m_data = (A3 == 5'd0) ? '0 : WD;
            m_count++;
        end else m_valid = 1'b0;
        #1;
    endtask

    task automatic check_all(input string tag);
        chk({tag, ".rd1"}, rd1, exp_rd(A1, 1'b1));
        chk({tag, ".rd2"}, rd2, exp_rd(A2, 1'b1));
        chk({tag, ".rd1_nb"}, rd1_nb, exp_rd(A1, 1'b0));
        chk({tag, ".rd2_nb"}, rd2_nb, exp_rd(A2, 1'b0));
        chk({tag, ".valid"}, 32'(valid), 32'(m_valid));
        chk({tag, ".pc"}, pc_o, m_pc);
        chk({tag, ".reg"}, 32'(reg_o), 32'(m_reg));
        chk({tag, ".data"}, data_o, m_data);
        chk({tag, ".count"}, cnt, m_count);
        chk({tag, ".count3"}, 32'(cnt_c3), m_count % 8);
    endtask

    initial begin
        model_clear();
        reset = 1'b1;
        drive(5'd5, 5'd31, 5'd0, '0, 1'b0, '0);
        #2;
        check_all("reset_held");
        reset = 1'b0;
        #1;
        check_all("reset_zero");
        // basic write then read
        drive(5'd8, 5'd8, 5'd8, 32'h1234_5678, 1'b1, 32'h3000);
        tick();
        drive(5'd8, 5'd0, 5'd0, '0, 1'b0, '0);
        #1;
        chk("basic.rd1", rd1, 32'h1234_5678);
        chk("basic.valid", 32'(valid), 32'd1);
        chk("basic.reg", 32'(reg_o), 32'd8);
        chk("basic.pc", pc_o, 32'h3000);
        chk("basic.count", cnt, 32'd1);
        check_all("basic");
        tick();
        check_all("basic_idle");
        // $0 protection
        drive(5'd0, 5'd0, 5'd0, 32'hFFFF_FFFF, 1'b1, 32'h3004);
        tick();
        drive(5'd0, 5'd8, 5'd0, '0, 1'b0, '0);
        #1;
        chk("zero.rd1", rd1, 32'd0);
        chk("zero.data", data_o, 32'd0);
        chk("zero.count", cnt, 32'd2);
        check_all("zero");
        // write-through vs stored value
        drive(5'd0, 5'd0, 5'd9, 32'hAAAA_0000, 1'b1, 32'h3008);
        tick();
        drive(5'd9, 5'd9, 5'd9, 32'h5555, 1'b1, 32'h300C);
        #1;
        chk("byp.rd1", rd1, 32'h5555);
        chk("byp.rd2", rd2, 32'h5555);
        chk("nobyp.rd1_pre", rd1_nb, 32'hAAAA_0000);
        check_all("byp_pre");
        tick();
        RegWr = 1'b0;
        #1;
        chk("nobyp.rd1_post", rd1_nb, 32'h5555);
        check_all("byp_post");
        // async reset between edges
        drive(5'd0, 5'd0, 5'd4, 32'd7, 1'b1, 32'h3010);
        tick();
        drive(5'd0, 5'd0, 5'd5, 32'd9, 1'b1, 32'h3014);
        tick();
        drive(5'd4, 5'd5, 5'd0, '0, 1'b0, '0);
        #1;
        check_all("pre_reset");
        #2;
        reset = 1'b1;
        model_clear();
        #1;
        chk("areset.rd1", rd1, 32'd0);
        chk("areset.count", cnt, 32'd0);
        check_all("areset");
        drive(5'd4, 5'd5, 5'd6, 32'h77, 1'b1, 32'h3018);
        tick();
        RegWr = 1'b0;
        #1;
        chk("reset_edge.count", cnt, 32'd0);
        check_all("reset_edge");
        reset = 1'b0;
        #1;
        check_all("reset_release");
        // 3-bit counter wraps 1..7,0,1
        for (int i = 0; i < 9; i++) begin
            drive(5'($urandom_range(0, 31)), 5'($urandom_range(0, 31)), 5'($urandom_range(0, 31)),
                  $urandom, 1'b1, $urandom);
            tick();
            chk("wrap.count3", 32'(cnt_c3), 32'((i + 1) % 8));
        end
        check_all("wrap");
        // randomized traffic with narrow address range to provoke collisions
        for (int i = 0; i < 400; i++) begin
            drive(5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)),
                  $urandom, 1'($urandom_range(0, 1)), $urandom);
            if (i % 4 == 0) begin
                A1 = 5'($urandom_range(0, 31));
                A3 = 5'($urandom_range(0, 31));
            end
            #1;
            check_all("rand_pre");
            tick();
            check_all("rand_post");
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
